// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the 8051 ALU writeback stage: opcode codes, selector
// encodings, PSW bit positions, FSM states and the flag-write mask.
package alu_writeback_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_ADDC = 5'h01;
  localparam logic [4:0] OP_SUBB = 5'h02;
  localparam logic [4:0] OP_MUL  = 5'h03;
  localparam logic [4:0] OP_DIV  = 5'h04;
  localparam logic [4:0] OP_RRC  = 5'h05;
  localparam logic [4:0] OP_RLC  = 5'h06;
  localparam logic [4:0] OP_ORL  = 5'h07;
  localparam logic [4:0] OP_ANL  = 5'h08;
  localparam logic [4:0] OP_DA   = 5'h09;
  localparam logic [4:0] OP_XRL  = 5'h0a;
  localparam logic [4:0] OP_MOV  = 5'h0b;
  localparam logic [4:0] OP_INC  = 5'h0c;
  localparam logic [4:0] OP_DEC  = 5'h0d;

  typedef enum logic [1:0] {
    DEST_ACC   = 2'd0,
    DEST_RAM   = 2'd1,
    DEST_DPTR  = 2'd2,
    DEST_FLAGS = 2'd3
  } dest_e;

  typedef enum logic [1:0] {
    SFR_ACC = 2'd0,
    SFR_B   = 2'd1,
    SFR_PSW = 2'd2
  } sfr_e;

  localparam int PSW_CY = 7;
  localparam int PSW_AC = 6;
  localparam int PSW_OV = 2;
  localparam int PSW_P  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB_A   = 2'd1,
    ST_WB_B   = 2'd2,
    ST_WB_MEM = 2'd3
  } wb_state_e;

  // cy_or: new CY is cy_in OR'd with the current CY (decimal adjust)
  typedef struct packed {
    logic cy_we;
    logic ac_we;
    logic ov_we;
    logic cy_clr;
    logic cy_or;
  } flag_mask_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Upstream ALU-result handshake into the writeback stage.
interface alu_writeback_if #(
  parameter int RAM_AW = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        alu_opcode;
  logic [1:0]        dest_sel;
  logic [RAM_AW-1:0] dest_addr;
  logic [7:0]        res_1;
  logic [7:0]        res_2;
  logic              cy_in;
  logic              ac_in;
  logic              ov_in;

  modport master (
    output in_valid, alu_opcode, dest_sel, dest_addr, res_1, res_2,
           cy_in, ac_in, ov_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_opcode, dest_sel, dest_addr, res_1, res_2,
           cy_in, ac_in, ov_in,
    output in_ready
  );
endinterface

// File: rtl/alu_wb_flagmask.sv
// Decodes which PSW flags a result may update from its opcode and destination.
module alu_wb_flagmask
  import alu_writeback_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [1:0]  dest_sel,
  output flag_mask_t  mask
);

  always_comb begin
    mask = '0;
    case (opcode)
      OP_ADD, OP_ADDC, OP_SUBB: begin
        mask.cy_we = 1'b1;
        mask.ac_we = 1'b1;
        mask.ov_we = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        mask.cy_we  = 1'b1;
        mask.cy_clr = 1'b1;
        mask.ov_we  = 1'b1;
      end
      OP_RRC, OP_RLC: mask.cy_we = 1'b1;
      // Logic ops only touch CY when they target the carry bit itself
      OP_ORL, OP_ANL: mask.cy_we = (dest_sel == DEST_FLAGS);
      OP_DA: begin
        mask.cy_we = 1'b1;
        mask.cy_or = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// 8051 ALU writeback stage: commits results to ACC/B/DPTR/PSW or internal RAM.
// Optional macro ALU_WB_DIV0_TRAP_EN: DIV with overflow commits only PSW and pulses div0_trap.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int RESET_SP_UNUSED = 0,
  parameter int RAM_AW          = 8
) (
  input  logic              clock,
  input  logic              reset,
  alu_writeback_if.slave    up,
  input  logic              sfr_wr_en,
  input  logic [1:0]        sfr_sel,
  input  logic [7:0]        sfr_data,
  output logic              ram_wr_en,
  output logic [RAM_AW-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  input  logic              ram_wr_ack,
  output logic [7:0]        acc_out,
  output logic [7:0]        b_out,
  output logic [7:0]        psw_out,
  output logic [15:0]       dptr_out,
`ifdef ALU_WB_DIV0_TRAP_EN
  output logic              div0_trap,
`endif
  output logic              retire
);

  if (RESET_SP_UNUSED != 0) begin : g_param_check
    $error("alu_writeback: RESET_SP_UNUSED is reserved and must be 0");
  end

  wb_state_e         state_q, state_d;
  logic [4:0]        op_q;
  logic [1:0]        dest_q;
  logic [RAM_AW-1:0] addr_q;
  logic [7:0]        r1_q, r2_q;
  logic              cy_q, ac_q, ov_q;
  logic [7:0]        acc_q, acc_d, b_q, b_d, psw_q, psw_d;
  logic [15:0]       dptr_q, dptr_d;
  flag_mask_t        mask;
  logic              trap;
  logic              accept;
  logic              two_byte;

  alu_wb_flagmask u_flagmask (
    .opcode   (op_q),
    .dest_sel (dest_q),
    .mask     (mask)
  );

`ifdef ALU_WB_DIV0_TRAP_EN
  assign trap      = (state_q == ST_WB_A) && (op_q == OP_DIV) && ov_q;
  assign div0_trap = trap;
`else
  assign trap = 1'b0;
`endif

  assign up.in_ready = (state_q == ST_IDLE);
  assign accept      = up.in_valid & up.in_ready;
  assign two_byte    = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    psw_d   = psw_q;
    dptr_d  = dptr_q;
    retire  = 1'b0;

    // Software writes first so any writeback to the same target overrides them
    if (sfr_wr_en) begin
      case (sfr_sel)
        SFR_ACC: acc_d = sfr_data;
        SFR_B:   b_d   = sfr_data;
        SFR_PSW: psw_d = sfr_data;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (up.in_valid) state_d = ST_WB_A;
      end
      ST_WB_A: begin
        if (!trap) begin
          case (dest_q)
            DEST_ACC:  acc_d  = r1_q;
            DEST_DPTR: dptr_d = {r2_q, r1_q};
            default: ;
          endcase
        end
        if (mask.cy_we)
          psw_d[PSW_CY] = ~mask.cy_clr & (cy_q | (mask.cy_or & psw_q[PSW_CY]));
        if (mask.ac_we) psw_d[PSW_AC] = ac_q;
        if (mask.ov_we) psw_d[PSW_OV] = ov_q;
        if (!trap && two_byte && dest_q == DEST_ACC) begin
          state_d = ST_WB_B;
        end else if (!trap && dest_q == DEST_RAM) begin
          state_d = ST_WB_MEM;
        end else begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB_B: begin
        b_d     = r2_q;
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WB_MEM: begin
        if (ram_wr_ack) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    psw_d[PSW_P] = ^acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      psw_q   <= '0;
      dptr_q  <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      addr_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      cy_q    <= 1'b0;
      ac_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      psw_q   <= psw_d;
      dptr_q  <= dptr_d;
      if (accept) begin
        op_q   <= up.alu_opcode;
        dest_q <= up.dest_sel;
        addr_q <= up.dest_addr;
        r1_q   <= up.res_1;
        r2_q   <= up.res_2;
        cy_q   <= up.cy_in;
        ac_q   <= up.ac_in;
        ov_q   <= up.ov_in;
      end
    end
  end

  assign ram_wr_en   = (state_q == ST_WB_MEM);
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = r1_q;
  assign acc_out     = acc_q;
  assign b_out       = b_q;
  assign psw_out     = psw_q;
  assign dptr_out    = dptr_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback; expected register state is queued per
// transaction and checked one cycle after the DUT retires it.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        sfr_wr_en;
  logic [1:0]  sfr_sel;
  logic [7:0]  sfr_data;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        ram_wr_ack;
  logic [7:0]  acc_out, b_out, psw_out;
  logic [15:0] dptr_out;
  logic        retire;
`ifdef ALU_WB_DIV0_TRAP_EN
  logic        div0_trap;
`endif

  always #5 clock = ~clock;

  alu_writeback_if #(.RAM_AW(8)) up ();

  alu_writeback #(.RESET_SP_UNUSED(0), .RAM_AW(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .up          (up),
    .sfr_wr_en   (sfr_wr_en),
    .sfr_sel     (sfr_sel),
    .sfr_data    (sfr_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_ack  (ram_wr_ack),
    .acc_out     (acc_out),
    .b_out       (b_out),
    .psw_out     (psw_out),
    .dptr_out    (dptr_out),
`ifdef ALU_WB_DIV0_TRAP_EN
    .div0_trap   (div0_trap),
`endif
    .retire      (retire)
  );

  typedef struct packed {
    logic [7:0]  acc;
    logic [7:0]  b;
    logic [7:0]  psw;
    logic [15:0] dptr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] acc, input logic [7:0] b,
                      input logic [7:0] psw, input logic [15:0] dptr);
    exp_t e;
    e.acc = acc; e.b = b; e.psw = psw; e.dptr = dptr;
    sb.push_back(e);
  endtask

  // Called at a negedge while idle; returns at the negedge of the WB_A cycle
  // with the inputs scrambled so late changes would corrupt any re-sample.
  task automatic send(input logic [4:0] op, input logic [1:0] dest, input logic [7:0] addr,
                      input logic [7:0] r1, input logic [7:0] r2,
                      input logic cy, input logic ac, input logic ov);
    up.alu_opcode = op; up.dest_sel = dest; up.dest_addr = addr;
    up.res_1 = r1; up.res_2 = r2; up.cy_in = cy; up.ac_in = ac; up.ov_in = ov;
    up.in_valid = 1'b1;
    @(negedge clock);
    up.in_valid = 1'b0;
    up.alu_opcode = OP_INC; up.dest_sel = ~dest; up.dest_addr = ~addr;
    up.res_1 = ~r1; up.res_2 = ~r2; up.cy_in = ~cy; up.ac_in = ~ac; up.ov_in = ~ov;
  endtask

  task automatic expect_retire(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (retire === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, "_retire_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clock);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_acc"},      {24'd0, acc_out}, {24'd0, e.acc});
      chk({tag, "_b"},        {24'd0, b_out},   {24'd0, e.b});
      chk({tag, "_psw"},      {24'd0, psw_out}, {24'd0, e.psw});
      chk({tag, "_dptr"},     {16'd0, dptr_out}, {16'd0, e.dptr});
      chk({tag, "_in_ready"}, {31'd0, up.in_ready}, 32'd1);
    end
  endtask

  task automatic sfr_write(input logic [1:0] sel, input logic [7:0] data);
    sfr_wr_en = 1'b1; sfr_sel = sel; sfr_data = data;
    @(negedge clock);
    sfr_wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    up.in_valid = 1'b0; up.alu_opcode = '0; up.dest_sel = '0; up.dest_addr = '0;
    up.res_1 = '0; up.res_2 = '0; up.cy_in = 1'b0; up.ac_in = 1'b0; up.ov_in = 1'b0;
    sfr_wr_en = 1'b0; sfr_sel = '0; sfr_data = '0; ram_wr_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, up.in_ready}, 32'd1);
    chk("rst_acc", {24'd0, acc_out}, 32'h00);
    chk("rst_b",   {24'd0, b_out},   32'h00);
    chk("rst_psw", {24'd0, psw_out}, 32'h00);
    chk("rst_dptr", {16'd0, dptr_out}, 32'h0000);
    chk("rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);

    // ADD into ACC: AC, OV set, CY clear, P of 0x80
    push(8'h80, 8'h00, 8'h45, 16'h0000);
    send(OP_ADD, DEST_ACC, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("add_retire_n1", {31'd0, retire}, 32'd1);
    chk("add_in_ready_n1", {31'd0, up.in_ready}, 32'd0);
    expect_retire("add");

    sfr_write(SFR_PSW, 8'h80);
    chk("sfr_psw_cy", {24'd0, psw_out}, 32'h81);

    // MUL: two-cycle commit, CY forced 0
    push(8'h00, 8'h19, 8'h04, 16'h0000);
    send(OP_MUL, DEST_ACC, 8'h00, 8'h00, 8'h19, 1'b1, 1'b1, 1'b1);
    chk("mul_in_ready_n1", {31'd0, up.in_ready}, 32'd0);
    chk("mul_retire_n1", {31'd0, retire}, 32'd0);
    @(negedge clock);
    chk("mul_acc_n2", {24'd0, acc_out}, 32'h00);
    chk("mul_in_ready_n2", {31'd0, up.in_ready}, 32'd0);
    chk("mul_retire_n2", {31'd0, retire}, 32'd1);
    expect_retire("mul");

    // RAM write, ack on the third WB_MEM cycle, in_valid held high meanwhile
    push(8'h00, 8'h19, 8'h04, 16'h0000);
    send(OP_MOV, DEST_RAM, 8'h30, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ram_en_wb_a", {31'd0, ram_wr_en}, 32'd0);
    up.in_valid = 1'b1; up.alu_opcode = OP_ADD; up.dest_sel = DEST_ACC; up.res_1 = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (c == 2) begin
        up.in_valid = 1'b0;
        ram_wr_ack = 1'b1;
        #1;
      end
      chk("ram_en_hold", {31'd0, ram_wr_en}, 32'd1);
      chk("ram_addr_hold", {24'd0, ram_wr_addr}, 32'h30);
      chk("ram_data_hold", {24'd0, ram_wr_data}, 32'h5A);
      chk("ram_in_ready", {31'd0, up.in_ready}, 32'd0);
      chk("ram_retire", {31'd0, retire}, {31'd0, c == 2});
    end
    expect_retire("ram");
    ram_wr_ack = 1'b0;
    chk("ram_en_drop", {31'd0, ram_wr_en}, 32'd0);

    // Reset during the second WB_MEM cycle abandons the write
    send(OP_MOV, DEST_RAM, 8'h40, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("rstmid_en_before", {31'd0, ram_wr_en}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ram_wr_ack = 1'b1;
    #1;
    chk("rstmid_ram_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rstmid_acc", {24'd0, acc_out}, 32'h00);
    chk("rstmid_b",   {24'd0, b_out},   32'h00);
    chk("rstmid_psw", {24'd0, psw_out}, 32'h00);
    chk("rstmid_in_ready", {31'd0, up.in_ready}, 32'd1);
    chk("rstmid_late_ack_retire", {31'd0, retire}, 32'd0);
    @(negedge clock);
    ram_wr_ack = 1'b0;
    chk("rstmid_ram_en_after", {31'd0, ram_wr_en}, 32'd0);
    chk("rstmid_in_ready_after", {31'd0, up.in_ready}, 32'd1);

    // Writeback beats a simultaneous SFR write to ACC
    push(8'h12, 8'h00, 8'h00, 16'h0000);
    send(OP_ADD, DEST_ACC, 8'h00, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0);
    sfr_wr_en = 1'b1; sfr_sel = SFR_ACC; sfr_data = 8'hFF;
    expect_retire("acc_collide");
    sfr_wr_en = 1'b0;

    sfr_write(SFR_PSW, 8'h44);
    chk("sfr_psw_44", {24'd0, psw_out}, 32'h44);

    // PSW collision: CY from RRC, other bits from sfr_data
    push(8'h09, 8'h00, 8'h98, 16'h0000);
    send(OP_RRC, DEST_ACC, 8'h00, 8'h09, 8'h00, 1'b1, 1'b1, 1'b1);
    sfr_wr_en = 1'b1; sfr_sel = SFR_PSW; sfr_data = 8'h18;
    expect_retire("psw_collide");
    sfr_wr_en = 1'b0;

    // Different registers: ACC from writeback, B from SFR port
    push(8'h03, 8'hAA, 8'h98, 16'h0000);
    send(OP_ADD, DEST_ACC, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
    sfr_wr_en = 1'b1; sfr_sel = SFR_B; sfr_data = 8'hAA;
    expect_retire("b_sfr");
    sfr_wr_en = 1'b0;

    push(8'h03, 8'hAA, 8'h98, 16'h1234);
    send(OP_XRL, DEST_DPTR, 8'h00, 8'h34, 8'h12, 1'b0, 1'b1, 1'b1);
    expect_retire("dptr");

    push(8'h03, 8'hAA, 8'h18, 16'h1234);
    send(OP_ANL, DEST_FLAGS, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    expect_retire("anl_flags");

    push(8'h25, 8'hAA, 8'h99, 16'h1234);
    send(OP_DA, DEST_ACC, 8'h00, 8'h25, 8'h00, 1'b1, 1'b0, 1'b0);
    expect_retire("da_set");

    push(8'h30, 8'hAA, 8'h98, 16'h1234);
    send(OP_DA, DEST_ACC, 8'h00, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_retire("da_keep");

    sfr_write(SFR_ACC, 8'h07);
    chk("pre_div_acc", {24'd0, acc_out}, 32'h07);
    chk("pre_div_psw", {24'd0, psw_out}, 32'h99);
    sfr_write(SFR_B, 8'h00);
    chk("pre_div_b", {24'd0, b_out}, 32'h00);

`ifdef ALU_WB_DIV0_TRAP_EN
    push(8'h07, 8'h00, 8'h1D, 16'h1234);
    send(OP_DIV, DEST_ACC, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    chk("div0_trap_pulse", {31'd0, div0_trap}, 32'd1);
    chk("div0_retire_n1", {31'd0, retire}, 32'd1);
    expect_retire("div0");
    chk("div0_trap_clear", {31'd0, div0_trap}, 32'd0);
    push(8'h07, 8'h00, 8'h1D, 16'h1234);
`else
    push(8'hFF, 8'hFF, 8'h1C, 16'h1234);
    send(OP_DIV, DEST_ACC, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    chk("div0_retire_n1", {31'd0, retire}, 32'd0);
    expect_retire("div0");
    push(8'hFF, 8'hFF, 8'h1C, 16'h1234);
`endif

    // Ack already high: single-cycle WB_MEM occupancy
    ram_wr_ack = 1'b1;
    send(OP_MOV, DEST_RAM, 8'h7F, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fast_ack_en_wb_a", {31'd0, ram_wr_en}, 32'd0);
    chk("fast_ack_retire_wb_a", {31'd0, retire}, 32'd0);
    @(negedge clock);
    chk("fast_ack_en", {31'd0, ram_wr_en}, 32'd1);
    chk("fast_ack_addr", {24'd0, ram_wr_addr}, 32'h7F);
    chk("fast_ack_data", {24'd0, ram_wr_data}, 32'hC3);
    expect_retire("fast_ack");
    ram_wr_ack = 1'b0;
    chk("fast_ack_en_drop", {31'd0, ram_wr_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
